// File: rtl/timestamp_reader.sv
// timestamp_reader: host-side master for the triggerer serial timestamp port.
// It watches DAT_RDY and, when set, raises DAT_ENA and clocks one word out MSB-first on DAT_CLK.
// Each assembled word is handed downstream over a valid/ready interface.
// Optional feature: define TRIGG_READER_EXTEND_EN to prepend an EXT_WIDTH-bit epoch.
// The epoch counts wraps of the raw counter.
//
// state | meaning
// IDLE  | waiting for rdy_s and room in the output register
// ENA   | dat_ena high, dat_clk low; the device loads its word
// SHI   | dat_clk high; sample dat_in on the last cycle
// SLO   | dat_clk low; the device shifts the next bit out
// DONE  | one cycle: publish the word, drop dat_ena
// GUARD | hold off while the device's DAT_RDY catches up with the pop

module timestamp_reader #(
   parameter int TS_WIDTH    = 24,
   parameter int HALF_PERIOD = 4,
   parameter int GUARD_CYC   = 8
`ifdef TRIGG_READER_EXTEND_EN
   , parameter int EXT_WIDTH = 8
   , localparam int OUT_W    = TS_WIDTH + EXT_WIDTH
`else
   , localparam int OUT_W    = TS_WIDTH
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dat_rdy,
   input  logic             dat_in,
   output logic             dat_ena,
   output logic             dat_clk,
   output logic [OUT_W-1:0] ts_word,
   output logic             ts_valid,
   input  logic             ts_ready,
   output logic             busy
);

   localparam int DIV_W = $clog2(HALF_PERIOD + 1);
   localparam int BIT_W = $clog2(TS_WIDTH + 1);
   localparam int GRD_W = $clog2(GUARD_CYC + 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_PERIOD - 1);
   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(TS_WIDTH);
   localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENA, S_SHI, S_SLO, S_DONE, S_GUARD
   } state_t;

   state_t              state_q, state_d;
   logic                rdy_s1_q, rdy_s_q;
   logic                din_s1_q, din_s_q;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [GRD_W-1:0]    grd_q, grd_d;
   logic [TS_WIDTH-1:0] shreg_q, shreg_d;
   logic [OUT_W-1:0]    ts_word_q, ts_word_d;
   logic                ts_valid_q, ts_valid_d;
   logic                dat_ena_q, dat_ena_d;
   logic                dat_clk_q, dat_clk_d;
`ifdef TRIGG_READER_EXTEND_EN
   logic [EXT_WIDTH-1:0] epoch_q, epoch_d;
   logic [TS_WIDTH-1:0]  prev_q, prev_d;
`endif

   // Next-state, counters, shift register and output word
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      grd_d      = grd_q;
      shreg_d    = shreg_q;
      ts_word_d  = ts_word_q;
      ts_valid_d = ts_valid_q;
`ifdef TRIGG_READER_EXTEND_EN
      epoch_d    = epoch_q;
      prev_d     = prev_q;
`endif
      if (ts_valid_q && ts_ready) begin
         ts_valid_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            // A pending unaccepted word blocks the fetch; the device keeps its word queued.
            if (rdy_s_q && (!ts_valid_q || ts_ready)) begin
               state_d = S_ENA;
               bit_d   = BIT_LOAD;
            end
         end
         S_ENA: begin
            if (div_q == '0) state_d = S_SHI;
         end
         S_SHI: begin
            if (div_q == '0) begin
               shreg_d = {shreg_q[TS_WIDTH-2:0], din_s_q};
               bit_d   = bit_q - BIT_W'(1);
               state_d = (bit_q == BIT_W'(1)) ? S_DONE : S_SLO;
            end
         end
         S_SLO: begin
            if (div_q == '0) state_d = S_SHI;
         end
         S_DONE: begin
`ifdef TRIGG_READER_EXTEND_EN
            if (shreg_q < prev_q) epoch_d = epoch_q + EXT_WIDTH'(1);
            prev_d    = shreg_q;
            ts_word_d = {epoch_d, shreg_q};
`else
            ts_word_d = shreg_q;
`endif
            ts_valid_d = 1'b1;
            state_d    = S_GUARD;
         end
         S_GUARD: begin
            if (grd_q == '0) state_d = S_IDLE;
            else             grd_d   = grd_q - GRD_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         div_d = DIV_LOAD;
      end else if (div_q != '0) begin
         div_d = div_q - DIV_W'(1);
      end
      if (state_d == S_GUARD && state_q != S_GUARD) begin
         grd_d = GRD_LOAD;
      end
      dat_ena_d = (state_d == S_ENA) || (state_d == S_SHI) || (state_d == S_SLO);
      dat_clk_d = (state_d == S_SHI);
   end

   // State, synchronisers and registered pin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rdy_s1_q   <= 1'b0;
         rdy_s_q    <= 1'b0;
         din_s1_q   <= 1'b0;
         din_s_q    <= 1'b0;
         div_q      <= '0;
         bit_q      <= '0;
         grd_q      <= '0;
         shreg_q    <= '0;
         ts_word_q  <= '0;
         ts_valid_q <= 1'b0;
         dat_ena_q  <= 1'b0;
         dat_clk_q  <= 1'b0;
`ifdef TRIGG_READER_EXTEND_EN
         epoch_q    <= '0;
         prev_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rdy_s1_q   <= dat_rdy;
         rdy_s_q    <= rdy_s1_q;
         din_s1_q   <= dat_in;
         din_s_q    <= din_s1_q;
         div_q      <= div_d;
         bit_q      <= bit_d;
         grd_q      <= grd_d;
         shreg_q    <= shreg_d;
         ts_word_q  <= ts_word_d;
         ts_valid_q <= ts_valid_d;
         dat_ena_q  <= dat_ena_d;
         dat_clk_q  <= dat_clk_d;
`ifdef TRIGG_READER_EXTEND_EN
         epoch_q    <= epoch_d;
         prev_q     <= prev_d;
`endif
      end
   end

   assign dat_ena  = dat_ena_q;
   assign dat_clk  = dat_clk_q;
   assign ts_word  = ts_word_q;
   assign ts_valid = ts_valid_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_timestamp_reader.sv
// Bench for timestamp_reader: device model, table vectors, corner sequences, random scoreboard.
module tb_timestamp_reader;
   localparam int TSW = 24;
`ifdef TRIGG_READER_EXTEND_EN
   localparam int EXTW  = 8;
   localparam int OUT_W = TSW + EXTW;
`else
   localparam int OUT_W = TSW;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             dat_rdy;
   logic             dat_in = 1'b0;
   logic             dat_ena, dat_clk, ts_valid, busy;
   logic             ts_ready;
   logic [OUT_W-1:0] ts_word;

   always #5 clk = ~clk;

   timestamp_reader dut (
      .clk      (clk),
      .rst      (rst),
      .dat_rdy  (dat_rdy),
      .dat_in   (dat_in),
      .dat_ena  (dat_ena),
      .dat_clk  (dat_clk),
      .ts_word  (ts_word),
      .ts_valid (ts_valid),
      .ts_ready (ts_ready),
      .busy     (busy)
   );

   // Triggerer device model: words offered in order, one popped per DAT_ENA rise
   logic [TSW-1:0] word_list [0:255];
   int             n_avail = 0;
   int             n_taken = 0;
   logic [TSW-1:0] dev_sr = '0;
   logic           ena_prev = 1'b0, dclk_prev = 1'b0;
   int             ena_rises = 0, dclk_rises = 0;

   assign dat_rdy = (n_avail > n_taken);

   always @(negedge clk) begin
      if (dat_ena && !ena_prev) begin
         dev_sr = word_list[n_taken[7:0]];
         n_taken++;
         ena_rises++;
      end else if (dat_ena && dclk_prev && !dat_clk) begin
         dev_sr = {dev_sr[TSW-2:0], 1'b0};
      end
      if (dat_clk && !dclk_prev) dclk_rises++;
      dat_in    = dev_sr[TSW-1];
      ena_prev  = dat_ena;
      dclk_prev = dat_clk;
   end

   // Reference model: raw word plus an epoch that counts strict decreases
   int             m_epoch;
   logic [TSW-1:0] m_prev;

   function automatic void model_reset();
      m_epoch = 0;
      m_prev  = '0;
   endfunction

   function automatic logic [OUT_W-1:0] model_next(input logic [TSW-1:0] raw);
`ifdef TRIGG_READER_EXTEND_EN
      if (raw < m_prev) m_epoch = (m_epoch + 1) % (1 << EXTW);
      m_prev = raw;
      return {EXTW'(m_epoch), raw};
`else
      m_prev = raw;
      return raw;
`endif
   endfunction

   function automatic logic [OUT_W-1:0] table_exp(input logic [TSW-1:0] raw, input int epoch);
`ifdef TRIGG_READER_EXTEND_EN
      return {EXTW'(epoch), raw};
`else
      return (epoch >= 0) ? raw : '0;
`endif
   endfunction

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [TSW-1:0] w);
      word_list[n_avail[7:0]] = w;
      n_avail++;
   endtask

   task automatic wait_valid(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (ts_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_ready();
      ts_ready = 1'b1;
      @(negedge clk);
      ts_ready = 1'b0;
   endtask

   typedef struct {
      logic [TSW-1:0] raw;
      int             epoch;
   } vec_t;

   vec_t           tbl [8];
   bit             ok;
   int             e_d, e_e, bad, got;
   logic [TSW-1:0] rw;
   logic [TSW-1:0] exp_q [$];

   initial begin
      tbl[0] = '{24'hA5C3F0, 0};
      tbl[1] = '{24'h000123, 1};
      tbl[2] = '{24'hFFFFF0, 1};
      tbl[3] = '{24'h000010, 2};
      tbl[4] = '{24'h000050, 2};
      tbl[5] = '{24'h000050, 2};
      tbl[6] = '{24'h000000, 3};
      tbl[7] = '{24'hFFFFFF, 3};

      rst = 1'b1;
      ts_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dat_ena", dat_ena, 0);
      check("rst_dat_clk", dat_clk, 0);
      check("rst_ts_valid", ts_valid, 0);
      check("rst_ts_word", ts_word, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      model_reset();
      @(negedge clk);

      // Table vectors: one fetch each, full handshake, back to idle
      for (int i = 0; i < 8; i++) begin
         e_d = dclk_rises;
         e_e = ena_rises;
         push(tbl[i].raw);
         wait_valid(1000, ok);
         check($sformatf("tbl%0d_valid", i), ok, 1);
         check($sformatf("tbl%0d_word", i), ts_word, table_exp(tbl[i].raw, tbl[i].epoch));
         check($sformatf("tbl%0d_dclk_edges", i), dclk_rises - e_d, 24);
         check($sformatf("tbl%0d_ena_rises", i), ena_rises - e_e, 1);
         void'(model_next(tbl[i].raw));
         pulse_ready();
         wait_idle(100, ok);
         check($sformatf("tbl%0d_idle", i), ok, 1);
         check($sformatf("tbl%0d_valid_clr", i), ts_valid, 0);
      end

      // Two queued words with downstream stalled
      e_e = ena_rises;
      push(24'h3C3C3C);
      push(24'h0F0F0F);
      wait_valid(1000, ok);
      check("full_first_valid", ok, 1);
      check("full_first_word", ts_word, model_next(24'h3C3C3C));
      repeat (200) @(negedge clk);
      check("full_no_second_fetch", ena_rises - e_e, 1);
      check("full_still_valid", ts_valid, 1);
      pulse_ready();
      wait_valid(1000, ok);
      check("full_second_valid", ok, 1);
      check("full_second_word", ts_word, model_next(24'h0F0F0F));
      check("full_second_fetch", ena_rises - e_e, 2);
      pulse_ready();
      wait_idle(100, ok);
      check("full_idle", ok, 1);

      // No data ready for 1000 cycles
      bad = 0;
      e_e = ena_rises;
      for (int i = 0; i < 1000; i++) begin
         if (dat_ena || dat_clk || busy || ts_valid) bad++;
         @(negedge clk);
      end
      check("quiet_bad_cycles", bad, 0);
      check("quiet_no_fetch", ena_rises - e_e, 0);

      // Reset mid-fetch after 10 bits; the next word must come through clean
      push(24'h5A5A5A);
      push(24'h000123);
      e_d = dclk_rises;
      for (int i = 0; i < 2000; i++) begin
         if (dclk_rises - e_d >= 10) break;
         @(negedge clk);
      end
      check("abort_reached_10_bits", (dclk_rises - e_d >= 10), 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_dat_ena", dat_ena, 0);
      check("abort_dat_clk", dat_clk, 0);
      check("abort_busy", busy, 0);
      check("abort_ts_valid", ts_valid, 0);
      rst = 1'b0;
      model_reset();
      wait_valid(1000, ok);
      check("abort_next_valid", ok, 1);
      check("abort_next_word", ts_word, model_next(24'h000123));
      pulse_ready();
      wait_idle(100, ok);
      check("abort_idle", ok, 1);

      // Random words, random backpressure, scoreboard in order
      got = 0;
      for (int cyc = 0; cyc < 20000 && got < 25; cyc++) begin
         if (n_avail - n_taken < 3 && exp_q.size() + got < 25 && $urandom_range(0, 99) < 3) begin
            rw = TSW'($urandom);
            if ($urandom_range(0, 3) == 0) rw = m_prev;
            push(rw);
            exp_q.push_back(rw);
         end
         ts_ready = ($urandom_range(0, 3) != 0);
         if (ts_valid && ts_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious_word", ts_word, 0);
            end else begin
               rw = exp_q.pop_front();
               check($sformatf("rand_word%0d", got), ts_word, model_next(rw));
            end
            got++;
         end
         @(negedge clk);
      end
      ts_ready = 1'b0;
      check("rand_word_count", got, 25);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
